// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             div_by_zero
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_NEG  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    acc;
    logic [W-1:0]    qr;
    logic [W-1:0]    mb;
    logic            is_div;
    logic            neg_lo;
    logic            neg_hi;

    logic [W:0]      add_c;
    logic [W:0]      sub_c;
    logic [SHW-1:0]  amt_c;
    logic [W-1:0]    alu_lo_c;
    logic            alu_carry_c;
    logic [W-1:0]    mag_a_c;
    logic [W-1:0]    mag_b_c;
    logic [W:0]      mul_sum_c;
    logic [W:0]      div_sh_c;
    logic [2*W-1:0]  prod_c;
    logic [W-1:0]    fix_lo_c;
    logic [W-1:0]    fix_hi_c;

    // Single-cycle datapath
    always_comb begin
        add_c       = {1'b0, A} + {1'b0, B};
        sub_c       = {1'b0, A} - {1'b0, B};
        amt_c       = B[SHW-1:0];
        alu_lo_c    = A & B;
        alu_carry_c = 1'b0;
        case (op)
            OP_OR:   alu_lo_c = A | B;
            OP_ADD:  begin alu_lo_c = add_c[W-1:0]; alu_carry_c = add_c[W]; end
            OP_SUB:  begin alu_lo_c = sub_c[W-1:0]; alu_carry_c = sub_c[W]; end
            OP_SHR:  alu_lo_c = A >> amt_c;
            OP_SHRA: alu_lo_c = $unsigned($signed(A) >>> amt_c);
            OP_SHL:  alu_lo_c = A << amt_c;
            OP_ROR:  alu_lo_c = W'({A, A} >> amt_c);
            OP_ROL:  alu_lo_c = W'(({A, A} << amt_c) >> W);
            OP_NEG:  alu_lo_c = W'(0) - A;
            OP_NOT:  alu_lo_c = ~A;
            default: alu_lo_c = A & B;
        endcase
    end

    // Operand magnitudes, one iteration step, and final sign fix-up
    always_comb begin
        mag_a_c   = A[W-1] ? W'(0) - A : A;
        mag_b_c   = B[W-1] ? W'(0) - B : B;
        mul_sum_c = {1'b0, acc} + (qr[0] ? {1'b0, mb} : '0);
        div_sh_c  = {acc, qr[W-1]};
        prod_c    = neg_lo ? (2*W)'(0) - {acc, qr} : {acc, qr};
        fix_lo_c  = prod_c[W-1:0];
        fix_hi_c  = prod_c[2*W-1:W];
        if (is_div) begin
            fix_lo_c = neg_lo ? W'(0) - qr : qr;
            fix_hi_c = neg_hi ? W'(0) - acc : acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            qr          <= '0;
            mb          <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            zero        <= 1'b1;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        carry       <= 1'b0;
                        div_by_zero <= 1'b0;
                        if (op == OP_MUL || (op == OP_DIV && B != '0)) begin
                            is_div <= (op == OP_DIV);
                            neg_lo <= A[W-1] ^ B[W-1];
                            neg_hi <= (op == OP_DIV) ? A[W-1] : (A[W-1] ^ B[W-1]);
                            acc    <= '0;
                            qr     <= mag_a_c;
                            mb     <= mag_b_c;
                            cnt    <= CW'(WIDTH - 1);
                            busy   <= 1'b1;
                            state  <= ITER;
                        end else if (op == OP_DIV) begin
                            div_by_zero <= 1'b1;
                            result_lo   <= '1;
                            result_hi   <= A;
                            zero        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            result_lo <= alu_lo_c;
                            result_hi <= {{(W-1){1'b0}}, alu_carry_c};
                            carry     <= alu_carry_c;
                            zero      <= (alu_lo_c == '0);
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ITER: begin
                    if (!is_div) begin
                        acc <= mul_sum_c[W:1];
                        qr  <= {mul_sum_c[0], qr[W-1:1]};
                    end else if (div_sh_c >= {1'b0, mb}) begin
                        acc <= W'(div_sh_c - {1'b0, mb});
                        qr  <= {qr[W-2:0], 1'b1};
                    end else begin
                        acc <= div_sh_c[W-1:0];
                        qr  <= {qr[W-2:0], 1'b0};
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    result_lo <= fix_lo_c;
                    result_hi <= fix_hi_c;
                    zero      <= (fix_lo_c == '0);
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8: directed vectors, randomized ops against an
// integer reference model, handshake, back-to-back and mid-op reset scenarios.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = '0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       busy, done, zero, carry, div_by_zero;
    logic [7:0] result_lo, result_hi;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .zero(zero), .carry(carry), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] o;
        logic [7:0] a, b, lo, hi;
        logic       c, dz;
        int         lat, bsy;
    } vec_t;

    // Reference: integer arithmetic straight from the operation definitions
    function automatic void model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] lo, output logic [7:0] hi,
                                  output logic c, output logic dz, output int lat);
        int ua, ub, sa, sb, n, r;
        longint p;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); n = ub % 8;
        lo = '0; hi = '0; c = 1'b0; dz = 1'b0; lat = 1;
        case (o)
            4'd0:  lo = a | b;
            4'd2:  begin r = ua + ub; lo = 8'(r); c = (r > 255); hi = {7'b0, c}; end
            4'd3:  begin r = ua - ub; lo = 8'(r); c = (ua < ub); hi = {7'b0, c}; end
            4'd4:  lo = 8'(ua >> n);
            4'd5:  lo = 8'(sa >>> n);
            4'd6:  lo = 8'(ua << n);
            4'd7:  lo = 8'((ua >> n) | (ua << (8 - n)));
            4'd8:  lo = 8'((ua << n) | (ua >> (8 - n)));
            4'd9:  lo = 8'(-sa);
            4'd10: lo = ~a;
            4'd11: begin p = longint'(sa) * longint'(sb); {hi, lo} = 16'(p); lat = 10; end
            4'd12: begin
                if (sb == 0) begin dz = 1'b1; lo = 8'hFF; hi = a; end
                else begin lo = 8'(sa / sb); hi = 8'(sa % sb); lat = 10; end
            end
            default: lo = a & b;
        endcase
    endfunction

    // Drive one request from IDLE; returns clocks to done (-1 on timeout) and busy cycles seen
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        lat = 0; bcnt = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 40);
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, result_lo, result_hi, zero, carry, div_by_zero} !== {2'b00, 16'h0000, 3'b100}) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b lo=%h hi=%h z=%b c=%b dz=%b, want 0 0 00 00 1 0 0",
                     busy, done, result_lo, result_hi, zero, carry, div_by_zero);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        vec_t v [13];
        int lat, bcnt;
        v[0]  = '{4'd2,  8'hF0, 8'h20, 8'h10, 8'h01, 1'b1, 1'b0, 1,  0};
        v[1]  = '{4'd3,  8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1,  0};
        v[2]  = '{4'd7,  8'h81, 8'h01, 8'hC0, 8'h00, 1'b0, 1'b0, 1,  0};
        v[3]  = '{4'd5,  8'h80, 8'h03, 8'hF0, 8'h00, 1'b0, 1'b0, 1,  0};
        v[4]  = '{4'd11, 8'hFD, 8'h07, 8'hEB, 8'hFF, 1'b0, 1'b0, 10, 9};
        v[5]  = '{4'd11, 8'h80, 8'h80, 8'h00, 8'h40, 1'b0, 1'b0, 10, 9};
        v[6]  = '{4'd12, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 10, 9};
        v[7]  = '{4'd12, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0, 10, 9};
        v[8]  = '{4'd12, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b0, 1'b1, 1,  0};
        v[9]  = '{4'd2,  8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 1'b0, 1,  0};
        v[10] = '{4'd14, 8'hCC, 8'hAA, 8'h88, 8'h00, 1'b0, 1'b0, 1,  0};
        v[11] = '{4'd3,  8'h03, 8'h05, 8'hFE, 8'h01, 1'b1, 1'b0, 1,  0};
        v[12] = '{4'd6,  8'h81, 8'h09, 8'h02, 8'h00, 1'b0, 1'b0, 1,  0};
        for (int i = 0; i < 13; i++) begin
            issue(v[i].o, v[i].a, v[i].b, lat, bcnt);
            n_vec++;
            if ({result_hi, result_lo, carry, div_by_zero, zero} !==
                {v[i].hi, v[i].lo, v[i].c, v[i].dz, (v[i].lo == 8'h00)} || lat != v[i].lat || bcnt != v[i].bsy) begin
                n_err++;
                $display("FAIL directed[%0d] op=%0d: got hi=%h lo=%h c=%b dz=%b z=%b lat=%0d busy=%0d, want hi=%h lo=%h c=%b dz=%b lat=%0d busy=%0d",
                         i, v[i].o, result_hi, result_lo, carry, div_by_zero, zero, lat, bcnt,
                         v[i].hi, v[i].lo, v[i].c, v[i].dz, v[i].lat, v[i].bsy);
            end
        end
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] corners [5];
        corners[0] = 8'h00; corners[1] = 8'h80; corners[2] = 8'hFF; corners[3] = 8'h7F; corners[4] = 8'h01;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return 8'($urandom);
    endfunction

    task automatic test_random();
        logic [3:0] o;
        logic [7:0] a, b, elo, ehi;
        logic       ec, edz;
        int         elat, lat, bcnt;
        for (int i = 0; i < 250; i++) begin
            o = 4'($urandom);
            a = pick();
            b = pick();
            model(o, a, b, elo, ehi, ec, edz, elat);
            issue(o, a, b, lat, bcnt);
            n_vec++;
            if ({result_hi, result_lo, carry, div_by_zero, zero} !== {ehi, elo, ec, edz, (elo == 8'h00)} || lat != elat) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h c=%b dz=%b z=%b lat=%0d, want hi=%h lo=%h c=%b dz=%b lat=%0d",
                         i, o, a, b, result_hi, result_lo, carry, div_by_zero, zero, lat, ehi, elo, ec, edz, elat);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] elo, ehi;
        logic       ec, edz;
        int         elat, lat;
        model(4'd11, 8'hB5, 8'h63, elo, ehi, ec, edz, elat);
        @(negedge clk);
        op = 4'd11; A = 8'hB5; B = 8'h63; start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            op = 4'($urandom); A = 8'($urandom); B = 8'($urandom); start = 1'b1;
        end while (!done && lat < 40);
        start = 1'b0;
        n_vec++;
        if ({result_hi, result_lo} !== {ehi, elo} || lat != elat || !done) begin
            n_err++;
            $display("FAIL busy_ignore: got hi=%h lo=%h lat=%0d, want hi=%h lo=%h lat=%0d", result_hi, result_lo, lat, ehi, elo, elat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av, bv, elo, ehi;
        logic       ec, edz;
        int         elat, k;
        av = 8'($urandom); bv = 8'($urandom); k = 0;
        @(negedge clk);
        op = 4'd2; A = av; B = bv; start = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                model(4'd2, av, bv, elo, ehi, ec, edz, elat);
                n_vec++;
                if ({result_hi, result_lo, carry} !== {ehi, elo, ec} || (cyc % 2) != 0) begin
                    n_err++;
                    $display("FAIL back_to_back[%0d] cyc=%0d: got hi=%h lo=%h c=%b, want hi=%h lo=%h c=%b on even cycle",
                             k, cyc, result_hi, result_lo, carry, ehi, elo, ec);
                end
                k++;
                av = 8'($urandom); bv = 8'($urandom);
                A = av; B = bv;
            end
            if (cyc == 19) start = 1'b0;
        end
        n_vec++;
        if (k != 10) begin
            n_err++;
            $display("FAIL back_to_back_rate: got %0d completions in 20 clocks, want 10", k);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        @(negedge clk);
        op = 4'd11; A = 8'd7; B = 8'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if ({busy, done, result_lo, result_hi, zero, carry, div_by_zero} !== {2'b00, 16'h0000, 3'b100}) begin
            n_err++;
            $display("FAIL reset_mid_op: got busy=%b done=%b lo=%h hi=%h z=%b c=%b dz=%b, want 0 0 00 00 1 0 0",
                     busy, done, result_lo, result_hi, zero, carry, div_by_zero);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d done pulses after reset, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
